// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core (word loads/stores only) with a Harvard memory interface.
// Latency: one instruction per clock; results are architecturally visible after the commit edge.
// Backpressure: none; the memories are combinational-read and must answer in the same cycle.
//
// Ports:
//   i_clk, i_reset      clock and synchronous active-high reset
//   i_instruction       instruction word fetched at o_pc
//   i_read_data         data word read at o_addr
//   i_startPC           PC loaded while i_reset is high (low two bits ignored)
//   o_pc                registered program counter
//   o_addr              data byte address (ALU result)
//   o_writeData         store data (rs2)
//   o_WE                data write enable, high only for SW and never during reset
//   o_testresult        current value of x10 (a0)
//
// Optional feature: define CPU_MUL_EN to execute MUL (funct7=0000001, funct3=000);
// otherwise that encoding decodes as a NOP.
module rv32i_single_cycle_core #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_instruction,
    input  logic [XLEN-1:0] i_read_data,
    input  logic [XLEN-1:0] i_startPC,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_addr,
    output logic [XLEN-1:0] o_writeData,
    output logic            o_WE,
    output logic [XLEN-1:0] o_testresult
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    localparam logic [XLEN-1:0] PC_ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] JALR_BIT0_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL
    } alu_op_e;

    typedef enum logic [1:0] {WB_ALU, WB_PC4, WB_MEM} wb_sel_e;

    // ---------------------------------------------------------------- state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rf_q [NUM_REGS];

    // ---------------------------------------------------------------- decode fields
    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;

    assign opcode = i_instruction[6:0];
    assign rd     = i_instruction[11:7];
    assign funct3 = i_instruction[14:12];
    assign rs1    = i_instruction[19:15];
    assign rs2    = i_instruction[24:20];
    assign funct7 = i_instruction[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:20]};
    assign imm_s = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign imm_b = {{(XLEN-13){i_instruction[31]}}, i_instruction[31], i_instruction[7],
                    i_instruction[30:25], i_instruction[11:8], 1'b0};
    assign imm_u = {i_instruction[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                    i_instruction[20], i_instruction[30:21], 1'b0};

    // Register reads are asynchronous; x0 is forced to zero on read.
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    logic [XLEN-1:0] pc_plus4;
    assign pc_plus4 = pc_q + XLEN'(4);

    // funct3 plus the funct7[5] "alternate" bit selects the integer ALU operation.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // ---------------------------------------------------------------- branch compare
    logic br_valid, br_taken;

    always_comb begin
        br_valid = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_valid = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- main decode
    logic [XLEN-1:0] alu_a, alu_b, alu_res, jalr_tgt;
    alu_op_e         alu_op;
    wb_sel_e         wb_sel;
    logic            rd_we, mem_we;

    // JALR target is kept off the shared ALU so decode never depends on the ALU output.
    assign jalr_tgt = (rs1_val + imm_i) & JALR_BIT0_MASK;

    always_comb begin
        alu_a  = rs1_val;
        alu_b  = rs2_val;
        alu_op = ALU_ADD;
        wb_sel = WB_ALU;
        rd_we  = 1'b0;
        mem_we = 1'b0;
        pc_d   = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                alu_b  = imm_u;
                alu_op = ALU_PASSB;
                rd_we  = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OPC_JAL: begin
                wb_sel = WB_PC4;
                rd_we  = 1'b1;
                pc_d   = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    alu_b  = imm_i;
                    wb_sel = WB_PC4;
                    rd_we  = 1'b1;
                    pc_d   = jalr_tgt;
                end
            end
            OPC_BRANCH: begin
                if (br_valid && br_taken) begin
                    pc_d = pc_q + imm_b;
                end
            end
            OPC_LOAD: begin
                alu_b = imm_i;
                if (funct3 == 3'b010) begin
                    wb_sel = WB_MEM;
                    rd_we  = 1'b1;
                end
            end
            OPC_STORE: begin
                alu_b = imm_s;
                if (funct3 == 3'b010) begin
                    mem_we = 1'b1;
                end
            end
            OPC_IMM: begin
                alu_b = imm_i;
                if (funct3 == 3'b001) begin
                    // SLLI: upper immediate bits must be zero.
                    alu_op = ALU_SLL;
                    rd_we  = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    // SRLI/SRAI: funct7 picks logical vs arithmetic; anything else is illegal.
                    alu_op = f3_to_op(funct3, funct7[5]);
                    rd_we  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    alu_op = f3_to_op(funct3, 1'b0);
                    rd_we  = 1'b1;
                end
            end
            OPC_REG: begin
                if (funct7 == 7'b0000000) begin
                    alu_op = f3_to_op(funct3, 1'b0);
                    rd_we  = 1'b1;
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    alu_op = f3_to_op(funct3, 1'b1);
                    rd_we  = 1'b1;
                end
`ifdef CPU_MUL_EN
                else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    alu_op = ALU_MUL;
                    rd_we  = 1'b1;
                end
`endif
            end
            default: begin
                // Unsupported opcodes (FENCE, SYSTEM, ...) fall through as NOP.
            end
        endcase
    end

    // ---------------------------------------------------------------- ALU
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:   alu_res = alu_a + alu_b;
            ALU_SUB:   alu_res = alu_a - alu_b;
            ALU_SLL:   alu_res = alu_a << alu_b[4:0];
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            ALU_XOR:   alu_res = alu_a ^ alu_b;
            ALU_SRL:   alu_res = alu_a >> alu_b[4:0];
            ALU_SRA:   alu_res = $signed(alu_a) >>> alu_b[4:0];
            ALU_OR:    alu_res = alu_a | alu_b;
            ALU_AND:   alu_res = alu_a & alu_b;
            ALU_PASSB: alu_res = alu_b;
`ifdef CPU_MUL_EN
            ALU_MUL:   alu_res = alu_a * alu_b;
`endif
            default:   alu_res = '0;
        endcase
    end

    logic [XLEN-1:0] rd_wdata;

    always_comb begin
        rd_wdata = alu_res;
        case (wb_sel)
            WB_PC4:  rd_wdata = pc_plus4;
            WB_MEM:  rd_wdata = i_read_data;
            default: rd_wdata = alu_res;
        endcase
    end

    // ---------------------------------------------------------------- state update
    // Reset has priority, so an instruction in flight during reset commits nothing.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q <= i_startPC & PC_ALIGN_MASK;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d & PC_ALIGN_MASK;
            if (rd_we && rd != 5'd0) begin
                rf_q[rd] <= rd_wdata;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign o_pc         = pc_q;
    assign o_addr       = alu_res;
    assign o_writeData  = rs2_val;
    assign o_WE         = mem_we & ~i_reset;
    assign o_testresult = rf_q[10];

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Scoreboard bench for rv32i_single_cycle_core: directed programs with hand-computed
// expectations queued per cycle; a negedge monitor compares whichever entries are due.
// The bench models instruction and data memory around the core.
module tb_rv32i_single_cycle_core;

    localparam int SEL_PC = 0, SEL_TR = 1, SEL_WE = 2, SEL_ADDR = 3, SEL_WD = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, we;
    logic [31:0] instr, rdata, start_pc, pc, addr, wdata, tr;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    rv32i_single_cycle_core dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_instruction (instr),
        .i_read_data   (rdata),
        .i_startPC     (start_pc),
        .o_pc          (pc),
        .o_addr        (addr),
        .o_writeData   (wdata),
        .o_WE          (we),
        .o_testresult  (tr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr = imem[pc[7:2]];
    assign rdata = dmem[addr[7:2]];
    always @(posedge clk) if (we) dmem[addr[7:2]] <= wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        int          sel;
        logic [31:0] val;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   test_id = 0;

    function automatic string sel_name(input int s);
        case (s)
            SEL_PC:   return "o_pc";
            SEL_TR:   return "o_testresult";
            SEL_WE:   return "o_WE";
            SEL_ADDR: return "o_addr";
            default:  return "o_writeData";
        endcase
    endfunction

    function automatic logic [31:0] sample(input int s);
        case (s)
            SEL_PC:   return pc;
            SEL_TR:   return tr;
            SEL_WE:   return {31'b0, we};
            SEL_ADDR: return addr;
            default:  return wdata;
        endcase
    endfunction

    // Monitor: compares every queued expectation that has come due this cycle.
    always @(negedge clk) begin : monitor
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                act = sample(sb[i].sel);
                checks++;
                if (act !== sb[i].val) begin
                    errors++;
                    $display("FAIL t%0d_%s cyc %0d: got %h, expected %h",
                             sb[i].tag, sel_name(sb[i].sel), cyc, act, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    // ------------------------------------------------------------ stimulus helpers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expect signal 'sel' == v at the monitor sample k cycles from now (k=0: this cycle).
    task automatic expect_at(input int k, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + k;
        e.sel = sel;
        e.val = v;
        e.tag = test_id;
        sb.push_back(e);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    // Two reset edges, checking the reset state after the first; returns with reset released.
    task automatic start(input logic [31:0] pc0);
        test_id++;
        rst      = 1'b1;
        start_pc = pc0;
        step(1);
        expect_at(0, SEL_PC, pc0 & 32'hFFFF_FFFC);
        expect_at(0, SEL_TR, 32'h0);
        expect_at(0, SEL_WE, 32'h0);
        step(1);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 30) begin
            step(1);
            n++;
        end
        if (sb.size() > 0) begin
            errors += sb.size();
            $display("FAIL drain_t%0d: %0d expectations never checked, expected 0", test_id, sb.size());
            sb.delete();
        end
    endtask

    // ------------------------------------------------------------ instruction encoders
    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return i_type(imm, rs1, 3'b000, rd, 7'h13);
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    // Branch table: funct3, x1 immediate, x2 immediate, expected PC after the branch.
    logic [2:0]  br_f3  [6] = '{3'b000, 3'b001, 3'b100, 3'b110, 3'b101, 3'b111};
    logic [11:0] br_a   [6] = '{12'h003, 12'h003, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    logic [11:0] br_b   [6] = '{12'h003, 12'h003, 12'h001, 12'h001, 12'h001, 12'h001};
    logic [31:0] br_exp [6] = '{32'h10,  32'h0C,  32'h10,  32'h0C,  32'h0C,  32'h10};

    initial begin
        rst      = 1'b1;
        start_pc = '0;
        for (int i = 0; i < 64; i++) dmem[i] = '0;
        clear_imem();

        // 1: NOP program from 0, PC sequencing, x0 write discarded.
        imem[1] = addi(5'd0, 5'd0, 12'h007);
        start(32'h0);
        for (int k = 0; k < 4; k++) begin
            expect_at(k, SEL_PC, 32'(4 * k));
            expect_at(k, SEL_TR, 32'h0);
            expect_at(k, SEL_WE, 32'h0);
        end
        drain();

        // 2: addi/add from 0x14.
        clear_imem();
        imem[5] = addi(5'd10, 5'd0, 12'd21);
        imem[6] = r_type(7'h00, 5'd10, 5'd10, 3'b000, 5'd10);
        start(32'h14);
        expect_at(1, SEL_TR, 32'd21);
        expect_at(1, SEL_PC, 32'h18);
        expect_at(2, SEL_TR, 32'h2A);
        expect_at(2, SEL_PC, 32'h1C);
        drain();

        // 3: store then load back.
        clear_imem();
        imem[0] = addi(5'd5, 5'd0, 12'h07F);
        imem[1] = sw(5'd5, 5'd0, 12'h008);
        imem[2] = i_type(12'h008, 5'd0, 3'b010, 5'd10, 7'h03);
        start(32'h0);
        expect_at(0, SEL_WE, 32'h0);
        expect_at(1, SEL_WE, 32'h1);
        expect_at(1, SEL_ADDR, 32'h8);
        expect_at(1, SEL_WD, 32'h7F);
        expect_at(2, SEL_WE, 32'h0);
        expect_at(2, SEL_ADDR, 32'h8);
        expect_at(3, SEL_TR, 32'h7F);
        drain();

        // 4: branch conditions including signed/unsigned boundaries (-1 vs 1).
        for (int b = 0; b < 6; b++) begin
            clear_imem();
            imem[0] = addi(5'd1, 5'd0, br_a[b]);
            imem[1] = addi(5'd2, 5'd0, br_b[b]);
            imem[2] = br(br_f3[b], 5'd1, 5'd2, 13'd8);
            start(32'h0);
            expect_at(2, SEL_PC, 32'h8);
            expect_at(3, SEL_PC, br_exp[b]);
            drain();
        end

        // 5: x0 immutable.
        clear_imem();
        imem[0] = addi(5'd10, 5'd0, 12'd9);
        imem[1] = addi(5'd0, 5'd0, 12'd5);
        imem[2] = r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd10);
        start(32'h0);
        expect_at(1, SEL_TR, 32'd9);
        expect_at(3, SEL_TR, 32'h0);
        drain();

        // 6: reset mid-program aborts a store and clears x10.
        clear_imem();
        imem[8]  = addi(5'd10, 5'd0, 12'd9);
        imem[9]  = sw(5'd10, 5'd0, 12'h040);
        imem[10] = addi(5'd10, 5'd10, 12'd1);
        start(32'h20);
        expect_at(1, SEL_TR, 32'd9);
        expect_at(1, SEL_PC, 32'h24);
        step(1);
        rst = 1'b1;
        expect_at(0, SEL_WE, 32'h0);
        expect_at(1, SEL_PC, 32'h20);
        expect_at(1, SEL_TR, 32'h0);
        step(1);
        rst = 1'b0;
        expect_at(1, SEL_TR, 32'd9);
        expect_at(1, SEL_PC, 32'h24);
        drain();

        // 7: MUL (build-dependent) and MULH-encoding NOP.
        clear_imem();
        imem[0] = addi(5'd1, 5'd0, 12'd6);
        imem[1] = addi(5'd2, 5'd0, 12'd7);
        imem[2] = addi(5'd10, 5'd0, 12'd5);
        imem[3] = r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd10);
        imem[4] = r_type(7'h01, 5'd2, 5'd1, 3'b001, 5'd10);
        start(32'h0);
        expect_at(3, SEL_TR, 32'd5);
`ifdef CPU_MUL_EN
        expect_at(4, SEL_TR, 32'd42);
        expect_at(5, SEL_TR, 32'd42);
`else
        expect_at(4, SEL_TR, 32'd5);
        expect_at(5, SEL_TR, 32'd5);
`endif
        expect_at(4, SEL_PC, 32'h10);
        expect_at(5, SEL_PC, 32'h14);
        drain();

        // 8: misaligned start PC; store held off during reset.
        clear_imem();
        imem[18] = sw(5'd0, 5'd0, 12'h03C);
        start(32'h4B);
        expect_at(0, SEL_WE, 32'h1);
        expect_at(0, SEL_ADDR, 32'h3C);
        expect_at(0, SEL_WD, 32'h0);
        expect_at(1, SEL_PC, 32'h4C);
        drain();

        // 9: LUI/AUIPC, shifts, JAL/JALR, SUB/SLT/SLTU, unsupported CSR and LB.
        clear_imem();
        imem[0]  = u_type(20'h12345, 5'd10, 7'h37);
        imem[1]  = u_type(20'h00001, 5'd10, 7'h17);
        imem[2]  = addi(5'd3, 5'd0, 12'hFF0);
        imem[3]  = i_type({7'h20, 5'd2}, 5'd3, 3'b101, 5'd10, 7'h13);
        imem[4]  = i_type({7'h00, 5'd28}, 5'd3, 3'b101, 5'd10, 7'h13);
        imem[5]  = jal(5'd10, 21'd12);
        imem[8]  = i_type(12'h031, 5'd0, 3'b000, 5'd10, 7'h67);
        imem[12] = r_type(7'h20, 5'd3, 5'd0, 3'b000, 5'd10);
        imem[13] = r_type(7'h00, 5'd0, 5'd3, 3'b011, 5'd10);
        imem[14] = r_type(7'h00, 5'd0, 5'd3, 3'b010, 5'd10);
        imem[15] = i_type(12'h300, 5'd3, 3'b001, 5'd10, 7'h73);
        imem[16] = i_type(12'h008, 5'd0, 3'b000, 5'd10, 7'h03);
        start(32'h0);
        expect_at(1,  SEL_TR, 32'h1234_5000);
        expect_at(2,  SEL_TR, 32'h0000_1004);
        expect_at(4,  SEL_TR, 32'hFFFF_FFFC);
        expect_at(5,  SEL_TR, 32'h0000_000F);
        expect_at(6,  SEL_TR, 32'h18);
        expect_at(6,  SEL_PC, 32'h20);
        expect_at(7,  SEL_TR, 32'h24);
        expect_at(7,  SEL_PC, 32'h30);
        expect_at(8,  SEL_TR, 32'd16);
        expect_at(9,  SEL_TR, 32'd0);
        expect_at(10, SEL_TR, 32'd1);
        expect_at(11, SEL_TR, 32'd1);
        expect_at(11, SEL_PC, 32'h40);
        expect_at(12, SEL_TR, 32'd1);
        expect_at(12, SEL_PC, 32'h44);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
